// File: rtl/led_matrix_scan_driver_if.sv
// Frame handover channel from the game logic into the LED scan driver.
// A transfer happens on a CLK1_50 rising edge when frame_valid && frame_ready.
interface led_matrix_scan_driver_if;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_scan_driver.sv
// Row-multiplexed 8x8 LED scan through two daisy-chained 74HC595s.
// Each row shifts a 16-bit word (row select + active-low cathodes) MSB first, latches it, then holds.
module led_matrix_scan_driver #(
    parameter int CLK_DIV  = 25,
    parameter int ROW_HOLD = 5000,
    parameter int ROWS     = 8,
    parameter int COLS     = 8
) (
    input  logic                      CLK1_50,
    input  logic                      CLR,
    led_matrix_scan_driver_if.slave   frame,
    output logic                      SER,
    output logic                      SRCLK,
    output logic                      RCLK,
    output logic                      OE_N,
    output logic [2:0]                row_idx,
    output logic [2:0]                dbg_state
);
    localparam int MAXV = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(ROW_HOLD - 1);
    localparam logic [3:0]    TOP_BIT = 4'(ROWS + COLS - 1);

    typedef enum logic [2:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic [15:0]            word;
    logic [ROWS*COLS-1:0]   active;
    logic [ROWS*COLS-1:0]   pending;
    logic                   pend_full;
    logic                   ready_q;

    logic                   swap;
    logic                   cap;
    logic                   full_next;
    logic                   row0_load_next;
    logic [ROWS*COLS-1:0]   src;
    logic [15:0]            load_word;

    always_comb begin
        swap           = (state == LOAD) && (row_idx == 3'd0) && pend_full;
        cap            = frame.frame_valid && ready_q;
        full_next      = cap ? 1'b1 : (swap ? 1'b0 : pend_full);
        row0_load_next = (state == HOLD) && (cnt == '0) && (row_idx == 3'd7);
        src            = swap ? pending : active;
        load_word      = {8'd1 << row_idx, ~src[{row_idx, 3'b000} +: 8]};
    end

    // Ready is also raised for the row-0 LOAD cycle itself: the swap frees the
    // pending slot that same edge, so a new frame can be captured alongside it.
    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            state     <= LOAD;
            cnt       <= '0;
            bit_idx   <= TOP_BIT;
            word      <= '0;
            SER       <= 1'b0;
            SRCLK     <= 1'b0;
            RCLK      <= 1'b0;
            OE_N      <= 1'b1;
            row_idx   <= 3'd0;
            active    <= '0;
            pending   <= '0;
            pend_full <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            if (swap) active <= pending;
            if (cap) pending <= frame.frame_data;
            pend_full <= full_next;
            ready_q   <= !full_next || row0_load_next;
            case (state)
                LOAD: begin
                    word    <= load_word;
                    bit_idx <= TOP_BIT;
                    SER     <= load_word[15];
                    SRCLK   <= 1'b0;
                    cnt     <= DIV_LD;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (cnt == '0) begin
                        SRCLK <= 1'b1;
                        cnt   <= DIV_LD;
                        state <= SHIFT_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (cnt == '0) begin
                        SRCLK <= 1'b0;
                        cnt   <= DIV_LD;
                        if (bit_idx == 4'd0) begin
                            RCLK  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                            SER     <= word[bit_idx - 4'd1];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == '0) begin
                        RCLK  <= 1'b0;
                        OE_N  <= 1'b0;
                        cnt   <= HOLD_LD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        row_idx <= row_idx + 3'd1;
                        state   <= LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign frame.frame_ready = ready_q;
    assign dbg_state         = state;
endmodule
